edlo_regfile: RTL and testbench

- Parametrised successor to the team's fixed 4x2-bit latch bank: a DEPTH x WIDTH register file.
- Features: explicit write strobe, auto-incrementing write pointer, synchronous clear, two registered read ports with write-first bypass, sticky address-error flag, flat dump of all entries.
- Sits between the tile pin decode and the output mux. The flat dump drives uo_out directly at default parameters.

---
 rtl/edlo_regfile.sv | 155 +++++++++++++++
 tb/tb_edlo_regfile.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/edlo_regfile.sv
// ---------------------------------------------------------------------------
// edlo_regfile
//   DEPTH x WIDTH register file with an explicit write strobe, an optional
//   auto-incrementing write pointer, and a synchronous clear. It has two
//   registered read ports with write-first bypass, a sticky address-error
//   flag, and a flat combinational dump of every entry.
//
// Parameters
//   WIDTH  : bits per entry (>= 1)
//   DEPTH  : number of entries (2..256)
//   ADDR_W : address width; DEPTH <= 2**ADDR_W
//
// Ports
//   clk        : clock; all state updates on the rising edge
//   rst_n      : synchronous active-low reset; highest priority
//   clr        : synchronous clear of entries, pointer, err and read data
//   wr_en      : write strobe
//   auto_inc   : 1 = write to the internal pointer; 0 = write to wr_addr
//   ptr_load   : load the pointer from wr_addr (the write also goes to wr_addr)
//   wr_addr    : explicit write address / pointer load value
//   wr_data    : write data
//   rd_addr_a  : read port A address
//   rd_addr_b  : read port B address
//   rd_data_a  : registered read data, port A (1-cycle latency)
//   rd_data_b  : registered read data, port B (1-cycle latency)
//   ptr        : current write pointer
//   err        : sticky out-of-range access flag
//   mem_flat   : all entries; entry i sits at [i*WIDTH +: WIDTH]
// ---------------------------------------------------------------------------
module edlo_regfile #(
  parameter int WIDTH  = 2,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   wr_en,
  input  logic                   auto_inc,
  input  logic                   ptr_load,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic [ADDR_W-1:0]      rd_addr_a,
  input  logic [ADDR_W-1:0]      rd_addr_b,
  output logic [WIDTH-1:0]       rd_data_a,
  output logic [WIDTH-1:0]       rd_data_b,
  output logic [ADDR_W-1:0]      ptr,
  output logic                   err,
  output logic [WIDTH*DEPTH-1:0] mem_flat
);

  typedef logic [WIDTH-1:0]  word_t;
  typedef logic [ADDR_W-1:0] addr_t;

  word_t mem_q [DEPTH];
  word_t mem_d [DEPTH];
  addr_t ptr_q, ptr_d;
  logic  err_q, err_d;
  word_t rd_a_q, rd_a_d;
  word_t rd_b_q, rd_b_d;

  addr_t ea;       // effective write address
  logic  wr_fire;  // a write actually lands in an entry this cycle

  // When DEPTH == 2**ADDR_W this is always true and err can never set.
  function automatic logic in_range(input addr_t a);
    return 32'(a) < DEPTH;
  endfunction

  always_comb begin
    // NOTE: every variable gets a hold/default value first so that no path
    // through the block leaves it unassigned, which would infer a latch.
    mem_d  = mem_q;
    ptr_d  = ptr_q;
    err_d  = err_q;
    rd_a_d = rd_a_q;
    rd_b_d = rd_b_q;

    // A pointer load redirects this cycle's write to wr_addr as well.
    ea      = ptr_load ? wr_addr : (auto_inc ? ptr_q : wr_addr);
    wr_fire = wr_en && in_range(ea);

    if (clr) begin
      // Clear drops any concurrent write and wins over any error source.
      for (int i = 0; i < DEPTH; i++) mem_d[i] = '0;
      ptr_d  = '0;
      err_d  = 1'b0;
      rd_a_d = '0;
      rd_b_d = '0;
    end else begin
      if (wr_en && !in_range(ea))       err_d = 1'b1;
      if (ptr_load && !in_range(wr_addr)) err_d = 1'b1;
      if (!in_range(rd_addr_a))         err_d = 1'b1;
      if (!in_range(rd_addr_b))         err_d = 1'b1;

      // Reads: write-first bypass, otherwise the stored entry. An
      // out-of-range address matches no entry and reads as zero.
      rd_a_d = '0;
      rd_b_d = '0;
      if (wr_fire && rd_addr_a == ea) begin
        rd_a_d = wr_data;
      end else begin
        for (int i = 0; i < DEPTH; i++)
          if (32'(rd_addr_a) == i) rd_a_d = mem_q[i];
      end
      if (wr_fire && rd_addr_b == ea) begin
        rd_b_d = wr_data;
      end else begin
        for (int i = 0; i < DEPTH; i++)
          if (32'(rd_addr_b) == i) rd_b_d = mem_q[i];
      end

      for (int i = 0; i < DEPTH; i++)
        if (wr_fire && 32'(ea) == i) mem_d[i] = wr_data;

      // The pointer advances even when the write itself was out of range.
      if (ptr_load) begin
        ptr_d = (wr_en && auto_inc) ? wr_addr + addr_t'(1) : wr_addr;
      end else if (wr_en && auto_inc) begin
        ptr_d = (32'(ptr_q) >= DEPTH - 1) ? '0 : ptr_q + addr_t'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the entries are architecturally visible through mem_flat and
      // must read as zero after reset, so the array is reset like any flop.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      ptr_q  <= '0;
      err_q  <= 1'b0;
      rd_a_q <= '0;
      rd_b_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values of
      // the previous cycle regardless of statement order.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      ptr_q  <= ptr_d;
      err_q  <= err_d;
      rd_a_q <= rd_a_d;
      rd_b_q <= rd_b_d;
    end
  end

  always_comb begin
    mem_flat = '0;
    for (int i = 0; i < DEPTH; i++) mem_flat[i*WIDTH +: WIDTH] = mem_q[i];
  end

  assign rd_data_a = rd_a_q;
  assign rd_data_b = rd_b_q;
  assign ptr       = ptr_q;
  assign err       = err_q;

endmodule

// File: tb/tb_edlo_regfile.sv
// ---------------------------------------------------------------------------
// tb_edlo_regfile
//   Three instances: default (W2 D4 A2), non-power-of-two depth (W2 D3 A2)
//   and a wide one (W8 D16 A4). A reference model updated on every rising
//   edge is compared against all outputs of every instance on each falling
//   edge; directed vectors also carry hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_edlo_regfile;

  localparam int N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n     [N];
  logic       clr       [N];
  logic       wr_en     [N];
  logic       auto_inc  [N];
  logic       ptr_load  [N];
  logic [3:0] wr_addr   [N];
  logic [7:0] wr_data   [N];
  logic [3:0] rd_addr_a [N];
  logic [3:0] rd_addr_b [N];

  logic [1:0]   rda0, rdb0, ptr0; logic err0; logic [7:0]   flat0;
  logic [1:0]   rda1, rdb1, ptr1; logic err1; logic [5:0]   flat1;
  logic [7:0]   rda2, rdb2;       logic [3:0] ptr2; logic err2; logic [127:0] flat2;

  edlo_regfile #(.WIDTH(2), .DEPTH(4), .ADDR_W(2)) dut0 (
    .clk(clk), .rst_n(rst_n[0]), .clr(clr[0]), .wr_en(wr_en[0]),
    .auto_inc(auto_inc[0]), .ptr_load(ptr_load[0]), .wr_addr(wr_addr[0][1:0]),
    .wr_data(wr_data[0][1:0]), .rd_addr_a(rd_addr_a[0][1:0]),
    .rd_addr_b(rd_addr_b[0][1:0]), .rd_data_a(rda0), .rd_data_b(rdb0),
    .ptr(ptr0), .err(err0), .mem_flat(flat0));

  edlo_regfile #(.WIDTH(2), .DEPTH(3), .ADDR_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n[1]), .clr(clr[1]), .wr_en(wr_en[1]),
    .auto_inc(auto_inc[1]), .ptr_load(ptr_load[1]), .wr_addr(wr_addr[1][1:0]),
    .wr_data(wr_data[1][1:0]), .rd_addr_a(rd_addr_a[1][1:0]),
    .rd_addr_b(rd_addr_b[1][1:0]), .rd_data_a(rda1), .rd_data_b(rdb1),
    .ptr(ptr1), .err(err1), .mem_flat(flat1));

  edlo_regfile #(.WIDTH(8), .DEPTH(16), .ADDR_W(4)) dut2 (
    .clk(clk), .rst_n(rst_n[2]), .clr(clr[2]), .wr_en(wr_en[2]),
    .auto_inc(auto_inc[2]), .ptr_load(ptr_load[2]), .wr_addr(wr_addr[2]),
    .wr_data(wr_data[2]), .rd_addr_a(rd_addr_a[2]), .rd_addr_b(rd_addr_b[2]),
    .rd_data_a(rda2), .rd_data_b(rdb2), .ptr(ptr2), .err(err2),
    .mem_flat(flat2));

  // Outputs gathered into uniform-width arrays for the compare process.
  logic [7:0]   o_rda  [N];
  logic [7:0]   o_rdb  [N];
  logic [3:0]   o_ptr  [N];
  logic         o_err  [N];
  logic [127:0] o_flat [N];

  always_comb begin
    o_rda[0] = 8'(rda0); o_rdb[0] = 8'(rdb0); o_ptr[0] = 4'(ptr0);
    o_err[0] = err0;     o_flat[0] = 128'(flat0);
    o_rda[1] = 8'(rda1); o_rdb[1] = 8'(rdb1); o_ptr[1] = 4'(ptr1);
    o_err[1] = err1;     o_flat[1] = 128'(flat1);
    o_rda[2] = rda2;     o_rdb[2] = rdb2;     o_ptr[2] = ptr2;
    o_err[2] = err2;     o_flat[2] = flat2;
  end

  function automatic int dep_of(input int k);
    case (k) 0: return 4; 1: return 3; default: return 16; endcase
  endfunction
  function automatic int aw_of(input int k);
    return (k == 2) ? 4 : 2;
  endfunction
  function automatic int w_of(input int k);
    return (k == 2) ? 8 : 2;
  endfunction

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] m_mem [N][16];
  int         m_ptr [N];
  bit         m_err [N];
  logic [7:0] m_rda [N];
  logic [7:0] m_rdb [N];

  initial begin
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < 16; i++) m_mem[k][i] = '0;
      m_ptr[k] = 0; m_err[k] = 0; m_rda[k] = '0; m_rdb[k] = '0;
    end
  end

  always @(posedge clk) begin
    int dep, amask, wa, ra, rb, ea;
    logic [7:0] wd;
    bit fire;
    for (int k = 0; k < N; k++) begin
      dep   = dep_of(k);
      amask = (1 << aw_of(k)) - 1;
      wd    = wr_data[k] & 8'((1 << w_of(k)) - 1);
      wa    = int'(wr_addr[k]) & amask;
      ra    = int'(rd_addr_a[k]) & amask;
      rb    = int'(rd_addr_b[k]) & amask;
      if (!rst_n[k] || clr[k]) begin
        for (int i = 0; i < 16; i++) m_mem[k][i] = '0;
        m_ptr[k] = 0; m_err[k] = 0; m_rda[k] = '0; m_rdb[k] = '0;
      end else begin
        ea   = ptr_load[k] ? wa : (auto_inc[k] ? m_ptr[k] : wa);
        fire = wr_en[k] && (ea < dep);
        if (wr_en[k] && ea >= dep)    m_err[k] = 1;
        if (ptr_load[k] && wa >= dep) m_err[k] = 1;
        if (ra >= dep) begin m_rda[k] = '0; m_err[k] = 1; end
        else m_rda[k] = (fire && ea == ra) ? wd : m_mem[k][ra];
        if (rb >= dep) begin m_rdb[k] = '0; m_err[k] = 1; end
        else m_rdb[k] = (fire && ea == rb) ? wd : m_mem[k][rb];
        if (fire) m_mem[k][ea] = wd;
        if (ptr_load[k])
          m_ptr[k] = (wr_en[k] && auto_inc[k]) ? ((wa + 1) & amask) : wa;
        else if (wr_en[k] && auto_inc[k])
          m_ptr[k] = (m_ptr[k] >= dep - 1) ? 0 : m_ptr[k] + 1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic [127:0] mflat;
    if (chk_en) begin
      for (int k = 0; k < N; k++) begin
        mflat = '0;
        for (int i = 0; i < dep_of(k); i++)
          mflat = mflat | (128'(m_mem[k][i]) << (i * w_of(k)));
        check($sformatf("i%0d rd_data_a", k), 128'(o_rda[k]), 128'(m_rda[k]));
        check($sformatf("i%0d rd_data_b", k), 128'(o_rdb[k]), 128'(m_rdb[k]));
        check($sformatf("i%0d ptr", k),       128'(o_ptr[k]), 128'(m_ptr[k]));
        check($sformatf("i%0d err", k),       128'(o_err[k]), 128'(m_err[k]));
        check($sformatf("i%0d mem_flat", k),  o_flat[k],      mflat);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle(input int k);
    clr[k] = 0; wr_en[k] = 0; auto_inc[k] = 0; ptr_load[k] = 0;
    wr_addr[k] = '0; wr_data[k] = '0; rd_addr_a[k] = '0; rd_addr_b[k] = '0;
  endtask

  task automatic wr(input int k, input bit ai, input bit pl, input int a,
                    input int d);
    idle(k);
    wr_en[k] = 1; auto_inc[k] = ai; ptr_load[k] = pl;
    wr_addr[k] = 4'(a); wr_data[k] = 8'(d);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    for (int k = 0; k < N; k++) begin idle(k); rst_n[k] = 0; end
    tick(); tick();
    chk_en = 1'b1;
    check("reset mem_flat", 128'(flat0), 128'h0);
    check("reset ptr",      128'(ptr0),  128'h0);
    check("reset err",      128'(err0),  128'h0);
    check("reset rd_a",     128'(rda0),  128'h0);
    for (int k = 0; k < N; k++) rst_n[k] = 1;

    // Explicit write then read back.
    wr(0, 0, 0, 2, 3); tick(); idle(0);
    check("write addr2 mem_flat", 128'(flat0), 128'h30);
    rd_addr_a[0] = 2; tick(); idle(0);
    check("read addr2", 128'(rda0), 128'h3);

    // Clear drops the concurrent write.
    wr(0, 0, 0, 1, 2); clr[0] = 1; tick(); idle(0);
    check("clr mem_flat", 128'(flat0), 128'h0);
    check("clr ptr",      128'(ptr0),  128'h0);

    // Pointer load, then auto-increment writes with wrap.
    ptr_load[0] = 1; wr_addr[0] = 2; tick(); idle(0);
    check("ptr_load", 128'(ptr0), 128'h2);
    wr(0, 1, 0, 0, 1); tick();
    wr(0, 1, 0, 0, 2); tick();
    wr(0, 1, 0, 0, 3); tick(); idle(0);
    check("auto_inc mem_flat", 128'(flat0), 128'h93);
    check("auto_inc ptr wrap", 128'(ptr0),  128'h1);

    // Write-first bypass on both ports.
    wr(0, 0, 0, 1, 2); rd_addr_a[0] = 1; rd_addr_b[0] = 1; tick(); idle(0);
    check("bypass a", 128'(rda0), 128'h2);
    check("bypass b", 128'(rdb0), 128'h2);

    // Pointer load together with an auto-inc write.
    wr(0, 1, 1, 1, 1); tick(); idle(0);
    check("load+write ptr",      128'(ptr0),  128'h2);
    check("load+write mem_flat", 128'(flat0), 128'h97);

    // Reset in the middle of a burst at ptr=2.
    wr(0, 1, 0, 0, 3); rst_n[0] = 0; tick(); rst_n[0] = 1; idle(0);
    check("mid-burst reset mem_flat", 128'(flat0), 128'h0);
    check("mid-burst reset ptr",      128'(ptr0),  128'h0);
    wr(0, 1, 0, 0, 1); tick(); idle(0);
    check("post-reset write", 128'(flat0), 128'h01);

    // Out-of-range handling on DEPTH=3.
    wr(1, 0, 0, 3, 3); tick(); idle(1);
    check("oor write mem_flat", 128'(flat1), 128'h0);
    check("oor write err",      128'(err1),  128'h1);
    rd_addr_a[1] = 3; tick(); idle(1);
    check("oor read data", 128'(rda1), 128'h0);
    wr(1, 0, 0, 0, 2); tick(); idle(1);
    check("err sticky",          128'(err1),  128'h1);
    check("legal write mem_flat", 128'(flat1), 128'h02);
    clr[1] = 1; tick(); idle(1);
    check("clr err", 128'(err1), 128'h0);

    ptr_load[1] = 1; wr_addr[1] = 1; tick();
    wr(1, 1, 0, 0, 1); tick();
    wr(1, 1, 0, 0, 2); tick(); idle(1);
    check("d3 wrap ptr",      128'(ptr1),  128'h0);
    check("d3 wrap mem_flat", 128'(flat1), 128'h24);

    ptr_load[1] = 1; wr_addr[1] = 3; tick(); idle(1);
    check("oor ptr_load ptr", 128'(ptr1), 128'h3);
    check("oor ptr_load err", 128'(err1), 128'h1);
    wr(1, 1, 0, 0, 3); tick(); idle(1);
    check("oor ptr inc wraps", 128'(ptr1),  128'h0);
    check("oor ptr no write",  128'(flat1), 128'h24);

    wr(1, 0, 0, 3, 1); clr[1] = 1; tick(); idle(1);
    check("clr beats oor", 128'(err1), 128'h0);

    // Wide instance: 16 auto-inc writes wrap the pointer.
    for (int i = 0; i < 16; i++) begin wr(2, 1, 0, 0, 16 + i); tick(); end
    idle(2);
    check("w8 ptr wrap",   128'(ptr2),           128'h0);
    check("w8 top entry",  128'(flat2[127:120]), 128'h1F);
    check("w8 low entry",  128'(flat2[7:0]),     128'h10);
    check("w8 err",        128'(err2),           128'h0);

    tick(); tick();
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
